bsg_skid_buffer_reset_n: RTL and testbench
==========================================

Name: bsg_skid_buffer_reset_n

Overview:
- Two-entry valid/ready skid buffer placed directly upstream of the design's reset data registers.
- Decouples a producer from a stalling consumer. Sustains one transfer per cycle with fully registered ready_o, v_o and data_o.
- Consumer side presents registered data, so the downstream register sees a clean, glitch-free source.

Parameters:
- width_p, 16, data path width in bits (>=1).

Ports:
- clk_i  input  1  rising-edge clock.
- reset_n_i  input  1  asynchronous, active-low reset.
- v_i  input  1  upstream data valid.
- data_i  input  width_p  upstream data.
- ready_o  output  1  buffer can accept data this cycle.
- v_o  output  1  data_o holds valid data.
- data_o  output  width_p  head entry.
- ready_i  input  1  downstream accepts data_o this cycle.
- els_o  output  2  occupancy, 0..2.

Behaviour:
- Interface: one clock, clk_i. Reset reset_n_i is asynchronous and active-low.
- Reset asserted (reset_n_i=0), taking effect immediately with no clock edge:
  - state=EMPTY; head and skid registers = 0.
  - v_o=0, data_o=0, els_o=0.
  - ready_o forced 0 (gated by reset).
- Reset release: ready_o=1 from deassertion onward (state EMPTY).
- Transfers: enq = v_i & ready_o; deq = v_o & ready_i. Evaluated on each rising clk_i edge.
- ready_o = (state != FULL). Derived from the state register only, never from ready_i or v_i, so there is no combinational in-to-out path on the handshake.
- v_o = (state != EMPTY). data_o = head register. els_o encodes the state: EMPTY=0, ONE=1, FULL=2.
- State machine (enq/deq sampled at the edge):
  - EMPTY, enq: head<=data_i, go to ONE.
  - EMPTY, no enq: hold. A deq cannot occur in EMPTY.
  - ONE, enq & deq: head<=data_i, stay in ONE. This is the full-throughput case.
  - ONE, enq & !deq: skid<=data_i, go to FULL.
  - ONE, !enq & deq: go to EMPTY. head keeps its stale value, and data_o is don't-care while v_o=0.
  - ONE, neither: hold.
  - FULL, deq: head<=skid, go to ONE. No enq is possible because ready_o=0.
  - FULL, !deq: hold both entries.
- Latency: data accepted at edge N is visible on data_o after edge N. Data is never bypassed combinationally.
- Ordering: strict FIFO. No entry is lost or duplicated.
- Stall protocol:
  - v_i with ready_o=0 is legal; the upstream holds its data.
  - The block never drops data.
  - v_o and data_o stay stable until deq.
- Reset mid-operation: all contents are discarded asynchronously. Outputs return to reset values within the same cycle.
- ready_i may toggle freely. It is ignored when v_o=0.
- No arithmetic beyond the 2-bit occupancy encoding. els_o never exceeds 2.

Test Plan:
- Reset check:
  - Stimulus: hold reset_n_i=0 mid-cycle with FULL contents 0xAAAA/0x5555.
  - Required: v_o=0, data_o=0x0000, ready_o=0, els_o=0 before the next clock edge.
  - After release: ready_o=1.
- Streaming:
  - Stimulus: ready_i=1, v_i=1 with data 0x0001..0x0010 on consecutive cycles.
  - Required: data_o outputs 0x0001..0x0010 one cycle later, one per cycle. els_o stays 1, ready_o stays 1.
- Backpressure:
  - Stimulus: ready_i=0, push 0x1234 then 0x5678.
  - Required: els_o goes 1 then 2; ready_o=0 after the second push.
  - Then a third v_i with 0x9ABC is held for 3 cycles and not accepted; data_o stays 0x1234.
- Drain with concurrent refill:
  - Stimulus: from FULL (0x1234, 0x5678), set ready_i=1 while v_i=1 with 0x9ABC.
  - Required outputs, in order: 0x1234, 0x5678, 0x9ABC.
  - ready_o returns to 1 after the first deq. Occupancy goes 2, 1, then 1, then 0.
- Random toggle:
  - Stimulus: random v_i and ready_i over 10k cycles.
  - Required: a scoreboard confirms in-order, lossless delivery. v_o and data_o are stable whenever v_o=1 and ready_i=0. ready_o equals (els_o != 2).
- Reset mid-stream:
  - Stimulus: assert reset_n_i during ONE, with an enq pending.
  - Required: the entry is discarded, and no stale value appears after release (first v_o carries the first post-reset data).

Source files
------------

// File: rtl/bsg_skid_buffer_reset_n_if.sv
// Handshake bundle for the two-entry skid buffer.
// Signal names are from the buffer's point of view: _i flows into the buffer, _o flows out.
interface bsg_skid_buffer_reset_n_if #(
  parameter int width_p = 16
);
  logic               v_i;
  logic [width_p-1:0] data_i;
  logic               ready_o;
  logic               v_o;
  logic [width_p-1:0] data_o;
  logic               ready_i;
  logic [1:0]         els_o;

  modport slave (
    input  v_i, data_i, ready_i,
    output ready_o, v_o, data_o, els_o
  );

  modport master (
    output v_i, data_i, ready_i,
    input  ready_o, v_o, data_o, els_o
  );
endinterface

// File: rtl/bsg_skid_buffer_reset_n.sv
// Two-entry valid/ready skid buffer: one transfer per cycle, data visible one edge after enq,
// ready_o depends only on the state register (held low while reset_n_i is asserted).
module bsg_skid_buffer_reset_n #(
  parameter int width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  bsg_skid_buffer_reset_n_if.slave   bus_if
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [width_p-1:0] head_q, head_d;
  logic [width_p-1:0] skid_q, skid_d;

  logic ready;
  logic valid;
  logic enq;
  logic deq;

  // Gating with the raw reset keeps the producer off the bus for the whole reset window.
  assign ready = reset_n_i & (state_q != FULL);
  assign valid = (state_q != EMPTY);
  assign enq   = bus_if.v_i & ready;
  assign deq   = valid & bus_if.ready_i;

  assign bus_if.ready_o = ready;
  assign bus_if.v_o     = valid;
  assign bus_if.data_o  = head_q;
  assign bus_if.els_o   = state_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (enq) begin
          head_d  = bus_if.data_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (enq && deq) begin
          head_d = bus_if.data_i;
        end else if (enq) begin
          skid_d  = bus_if.data_i;
          state_d = FULL;
        end else if (deq) begin
          // head keeps its stale value; data_o is don't-care while v_o is low
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (deq) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_bsg_skid_buffer_reset_n.sv
// Scoreboard bench for the two-entry skid buffer: stimulus pushes accepted words, a negedge
// monitor checks occupancy/ready against a counter model and pops on every dequeue.
module tb_bsg_skid_buffer_reset_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bsg_skid_buffer_reset_n_if #(.width_p(16)) bus ();

  bsg_skid_buffer_reset_n #(.width_p(16)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus_if    (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          mcnt  = 0;
  logic [15:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs; the counter model decides acceptance independently of the DUT.
  task automatic step(input logic v, input logic [15:0] d, input logic r, output logic acc);
    logic enq, deq;
    bus.v_i     = v;
    bus.data_i  = d;
    bus.ready_i = r;
    enq = v && (mcnt != 2);
    deq = r && (mcnt != 0);
    if (enq) exp_q.push_back(d);
    acc = enq;
    @(posedge clk);
    mcnt = mcnt + int'(enq) - int'(deq);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("els", {30'd0, bus.els_o}, mcnt);
      check("ready", {31'd0, bus.ready_o}, {31'd0, mcnt != 2});
      check("valid", {31'd0, bus.v_o}, {31'd0, mcnt != 0});
      if (prev_stall) begin
        check("stall_v", {31'd0, bus.v_o}, 32'd1);
        check("stall_data", {16'd0, bus.data_o}, {16'd0, prev_data});
      end
      if (bus.v_o) begin
        if (exp_q.size() == 0) begin
          check("spurious_v", {31'd0, bus.v_o}, 32'd0);
        end else begin
          check("head", {16'd0, bus.data_o}, {16'd0, exp_q[0]});
          if (bus.ready_i) void'(exp_q.pop_front());
        end
      end
      prev_stall = bus.v_o && !bus.ready_i;
      prev_data  = bus.data_o;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic resync_after_reset();
    bus.v_i = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    mcnt   = 0;
    mon_en = 1'b1;
  endtask

  initial begin
    logic        acc;
    logic [15:0] nd;
    bus.v_i = 1'b0;
    bus.data_i = '0;
    bus.ready_i = 1'b0;

    // Power-on reset values
    #2;
    check("por_v", {31'd0, bus.v_o}, 32'd0);
    check("por_ready", {31'd0, bus.ready_o}, 32'd0);
    check("por_els", {30'd0, bus.els_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rel_ready", {31'd0, bus.ready_o}, 32'd1);
    resync_after_reset();

    // Fill to FULL, then assert reset mid-cycle
    step(1'b1, 16'hAAAA, 1'b0, acc);
    step(1'b1, 16'h5555, 1'b0, acc);
    mon_en = 1'b0;
    bus.v_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_v", {31'd0, bus.v_o}, 32'd0);
    check("rst_data", {16'd0, bus.data_o}, 32'h0000);
    check("rst_ready", {31'd0, bus.ready_o}, 32'd0);
    check("rst_els", {30'd0, bus.els_o}, 32'd0);
    #1 rst_n = 1'b1;
    #1;
    check("rst_rel_ready", {31'd0, bus.ready_o}, 32'd1);
    resync_after_reset();

    // Streaming at full throughput
    for (int i = 1; i <= 16; i++) step(1'b1, 16'(i), 1'b1, acc);
    step(1'b0, 16'h0, 1'b1, acc);

    // Backpressure: two accepted, third held off for three cycles
    step(1'b1, 16'h1234, 1'b0, acc);
    step(1'b1, 16'h5678, 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h9ABC, 1'b0, acc);
      check("held_not_acc", {31'd0, acc}, 32'd0);
    end

    // Drain with concurrent refill
    step(1'b1, 16'h9ABC, 1'b1, acc);
    step(1'b1, 16'h9ABC, 1'b1, acc);
    step(1'b0, 16'h0, 1'b1, acc);
    check("drained_q", exp_q.size(), 32'd0);

    // Random toggling; upstream holds a word until it is accepted
    nd = 16'h0100;
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), nd, 1'($urandom_range(0, 1)), acc);
      if (acc) nd = nd + 16'd1;
    end
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, acc);
    check("rand_drained_q", exp_q.size(), 32'd0);

    // Reset during ONE with an enqueue pending
    step(1'b1, 16'h0777, 1'b1, acc);
    mon_en = 1'b0;
    bus.v_i = 1'b1;
    bus.data_i = 16'h0888;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_v", {31'd0, bus.v_o}, 32'd0);
    #1 rst_n = 1'b1;
    resync_after_reset();
    check("post_rst_v", {31'd0, bus.v_o}, 32'd0);
    step(1'b1, 16'h0BEE, 1'b1, acc);
    step(1'b0, 16'h0, 1'b1, acc);
    step(1'b0, 16'h0, 1'b1, acc);
    check("post_rst_q", exp_q.size(), 32'd0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
